jram_ctrl: RTL

- Two-port arbiter and sequencer for the 256x8 gate-level RAM, which has an address latch loaded by a level set strobe, a data set strobe and a data enable on a shared bidirectional bus.
- Accepts whole read/write transactions from two requesters (e.g. CPU fetch path and a loader/DMA).
- Picks one requester and generates the strobe sequence: address load, address hold, data set or enable, then acknowledge.
- Sits between the requesters and the RAM. The top level owns the tristate on the shared data bus, using this block's bio_out/bio_oe.

---
 rtl/jram_ctrl_pkg.sv | 23 ++
 rtl/jram_arb2.sv | 44 ++++
 rtl/jram_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/jram_ctrl_pkg.sv
// jram_ctrl_pkg: shared types and constants for the 256x8 RAM controller.
// Used by jram_ctrl and jram_arb2.
package jram_ctrl_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_AHOLD,
    S_WSET,
    S_WHOLD,
    S_RD,
    S_DONE
  } state_t;

  // Width of the strobe down-counter; covers SET_CYCLES up to 15
  localparam int CNT_W = 4;

  // Requester index encoding
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/jram_arb2.sv
// jram_arb2: two-way request arbiter.
// Build option JRAM_CTRL_RR_EN selects round-robin arbitration with a
// registered priority pointer; otherwise req0 has fixed priority.
module jram_arb2
  import jram_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic req0,
  input  logic req1,
  input  logic adv,        // grant taken this cycle
  output logic gnt_valid,
  output logic gnt_idx
);

  assign gnt_valid = req0 | req1;

`ifdef JRAM_CTRL_RR_EN
  logic ptr;

  // Pointed-to requester wins a tie, otherwise the only requester wins
  always_comb begin
    if (req0 && req1) gnt_idx = ptr;
    else if (req0)    gnt_idx = REQ0;
    else              gnt_idx = REQ1;
  end

  // Pointer moves to the requester that did not win each accepted grant
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  ptr <= REQ0;
    else if (adv)  ptr <= ~gnt_idx;
  end
`else
  // Fixed priority: req0 always wins
  always_comb begin
    gnt_idx = req0 ? REQ0 : REQ1;
  end

  // Clock, reset and advance are only needed by the round-robin pointer
  logic unused_arb;
  assign unused_arb = &{1'b0, clk, reset_n, adv};
`endif

endmodule

// File: rtl/jram_ctrl.sv
// jram_ctrl: arbiter and strobe sequencer for the 256x8 gate-level RAM.
// Sequence per transaction: address set strobe, address hold, then either
// data set strobe + hold (write) or data enable (read), then one-cycle ack.
// Build option JRAM_CTRL_RR_EN enables round-robin arbitration (see jram_arb2).
module jram_ctrl
  import jram_ctrl_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int SET_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0,
  input  logic             req1,
  input  logic             wr0,
  input  logic             wr1,
  input  logic [WIDTH-1:0] addr0,
  input  logic [WIDTH-1:0] addr1,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  output logic             ack0,
  output logic             ack1,
  output logic [WIDTH-1:0] rdata,
  output logic             busy,
  output logic [WIDTH-1:0] ram_bas,
  output logic             ram_wsa,
  output logic             ram_ws,
  output logic             ram_we,
  output logic [WIDTH-1:0] ram_bio_out,
  output logic             ram_bio_oe,
  input  logic [WIDTH-1:0] ram_bio_in
);

  // Counter reload: strobe stays high for SET_CYCLES cycles
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SET_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             sel;        // granted requester
  logic             wr_lat;
  logic [WIDTH-1:0] wdata_lat;
  logic             gnt_valid;
  logic             gnt_idx;
  logic             adv;

  assign adv  = (state == S_IDLE) && gnt_valid;
  assign busy = (state != S_IDLE);

  jram_arb2 u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .req0      (req0),
    .req1      (req1),
    .adv       (adv),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Sequencer: state, strobe counter and all registered RAM/requester outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      sel         <= REQ0;
      wr_lat      <= 1'b0;
      wdata_lat   <= '0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      rdata       <= '0;
      ram_bas     <= '0;
      ram_wsa     <= 1'b0;
      ram_ws      <= 1'b0;
      ram_we      <= 1'b0;
      ram_bio_out <= '0;
      ram_bio_oe  <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        S_IDLE: begin
          if (gnt_valid) begin
            sel       <= gnt_idx;
            wr_lat    <= (gnt_idx == REQ1) ? wr1 : wr0;
            ram_bas   <= (gnt_idx == REQ1) ? addr1 : addr0;
            wdata_lat <= (gnt_idx == REQ1) ? wdata1 : wdata0;
            ram_wsa   <= 1'b1;
            cnt       <= CNT_INIT;
            state     <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (cnt == '0) begin
            ram_wsa <= 1'b0;
            state   <= S_AHOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_AHOLD: begin
          if (wr_lat) begin
            ram_bio_oe  <= 1'b1;
            ram_bio_out <= wdata_lat;
            ram_ws      <= 1'b1;
            cnt         <= CNT_INIT;
            state       <= S_WSET;
          end else begin
            ram_we <= 1'b1;
            state  <= S_RD;
          end
        end
        S_WSET: begin
          if (cnt == '0) begin
            ram_ws <= 1'b0;
            state  <= S_WHOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_WHOLD: begin
          ram_bio_oe <= 1'b0;
          ack0       <= (sel == REQ0);
          ack1       <= (sel == REQ1);
          state      <= S_DONE;
        end
        S_RD: begin
          ram_we <= 1'b0;
          rdata  <= ram_bio_in;
          ack0   <= (sel == REQ0);
          ack1   <= (sel == REQ1);
          state  <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
